// File: rtl/div_fmt_pkg.sv
// Shared constants and FSM state type for the divider-result BCD formatter.
package div_fmt_pkg;

  localparam int N       = 8;  // magnitude width of quotient and remainder
  localparam int D       = 3;  // BCD digits per formatted value
  localparam int DIGIT_W = 4;  // bits per BCD digit

  typedef enum logic [1:0] {
    IDLE,
    CONV_RES,
    CONV_REM,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in one binary bit.
module bcd_dabble_step #(
  parameter int D = div_fmt_pkg::D
) (
  input  logic [4*D-1:0] acc_i,
  input  logic           bit_i,
  output logic [4*D-1:0] acc_o
);
  import div_fmt_pkg::DIGIT_W;

  logic [4*D-1:0] corr;
  logic           unused_carry;

  always_comb begin
    // NOTE: default assignment first so no path leaves corr unassigned (no latch).
    corr = acc_i;
    for (int i = 0; i < D; i++) begin
      if (acc_i[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) begin
        corr[i*DIGIT_W +: DIGIT_W] = acc_i[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
      end
    end
  end

  // The top corrected bit is shifted out; it is always 0 for in-range magnitudes.
  assign acc_o        = {corr[4*D-2:0], bit_i};
  assign unused_carry = corr[4*D-1];

endmodule

// File: rtl/div_result_bcd.sv
// Formats a sign-magnitude quotient and its remainder into BCD, one
// double-dabble iteration per cycle: N cycles for the quotient, N for the remainder.
module div_result_bcd #(
  parameter int N = div_fmt_pkg::N,
  parameter int D = div_fmt_pkg::D
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N:0]     res_in,
  input  logic [N:0]     rem_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           res_sign,
  output logic [4*D-1:0] res_bcd,
  output logic [4*D-1:0] rem_bcd
);
  import div_fmt_pkg::state_e;
  import div_fmt_pkg::IDLE;
  import div_fmt_pkg::CONV_RES;
  import div_fmt_pkg::CONV_REM;
  import div_fmt_pkg::DONE;

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e           state_q;
  logic [2*N-1:0]   mag_q;       // {quotient magnitude, remainder magnitude}, MSB shifted out first
  logic [4*D-1:0]   acc_q;
  logic [4*D-1:0]   step_acc;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             res_sign_q;
  logic [4*D-1:0]   res_bcd_q;
  logic [4*D-1:0]   rem_bcd_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             last_iter;
  logic             unused_rem_sign;

  assign unused_rem_sign = rem_in[N];
  assign last_iter       = (cnt_q == CNT_W'(N - 1));

  // Single step instance shared by both phases; the shift register feeds it one bit per cycle.
  bcd_dabble_step #(.D(D)) u_step (
    .acc_i (acc_q),
    .bit_i (mag_q[2*N-1]),
    .acc_o (step_acc)
  );

  // NOTE: non-blocking assignments only: every register here samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      res_sign_q  <= 1'b0;
      res_bcd_q   <= '0;
      rem_bcd_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q      <= {res_in[N-1:0], rem_in[N-1:0]};
            sign_q     <= res_in[N] & (|res_in[N-1:0]);  // no negative zero
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CONV_RES;
          end
        end
        CONV_RES: begin
          mag_q <= {mag_q[2*N-2:0], 1'b0};
          if (last_iter) begin
            res_bcd_q  <= step_acc;
            res_sign_q <= sign_q;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= CONV_REM;
          end else begin
            acc_q <= step_acc;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CONV_REM: begin
          mag_q <= {mag_q[2*N-2:0], 1'b0};
          if (last_iter) begin
            rem_bcd_q   <= step_acc;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q <= step_acc;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Return to IDLE only; the next capture happens at the following edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res_sign  = res_sign_q;
  assign res_bcd   = res_bcd_q;
  assign rem_bcd   = rem_bcd_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed self-checking bench for div_result_bcd: latency, formatting, hold, reset abort, back-to-back.
module tb_div_result_bcd;
  localparam int N = 8;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N:0]     res_in;
  logic [N:0]     rem_in;
  logic           out_valid;
  logic           out_ready;
  logic           res_sign;
  logic [4*D-1:0] res_bcd;
  logic [4*D-1:0] rem_bcd;

  int tests = 0;
  int fails = 0;

  logic [N:0]     b2b_res  [3];
  logic [N:0]     b2b_rem  [3];
  logic           b2b_sign [3];
  logic [4*D-1:0] b2b_rbcd [3];
  logic [4*D-1:0] b2b_mbcd [3];

  always #5 clk = ~clk;

  div_result_bcd #(.N(N), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_in    (res_in),
    .rem_in    (rem_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_sign  (res_sign),
    .res_bcd   (res_bcd),
    .rem_bcd   (rem_bcd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic s, input logic [11:0] rb, input logic [11:0] mb);
    check({tag, "_sign"}, 32'(res_sign), 32'(s));
    check({tag, "_res"},  32'(res_bcd),  32'(rb));
    check({tag, "_rem"},  32'(rem_bcd),  32'(mb));
  endtask

  task automatic capture(input logic [N:0] r, input logic [N:0] m);
    in_valid = 1'b1;
    res_in   = r;
    rem_in   = m;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the capture edge: out_valid must rise exactly 16 edges later.
  task automatic check_latency(input string tag);
    ticks(15);
    check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},        32'(in_ready),  32'd0);
    tick();
    check({tag, "_valid"},       32'(out_valid), 32'd1);
  endtask

  initial begin
    b2b_res[0] = 9'h0FF; b2b_rem[0] = 9'h0C7; b2b_sign[0] = 1'b0; b2b_rbcd[0] = 12'h255; b2b_mbcd[0] = 12'h199;
    b2b_res[1] = 9'h163; b2b_rem[1] = 9'h00C; b2b_sign[1] = 1'b1; b2b_rbcd[1] = 12'h099; b2b_mbcd[1] = 12'h012;
    b2b_res[2] = 9'h001; b2b_rem[2] = 9'h0FE; b2b_sign[2] = 1'b0; b2b_rbcd[2] = 12'h001; b2b_mbcd[2] = 12'h254;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    res_in    = '0;
    rem_in    = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_out("rst", 1'b0, 12'h000, 12'h000);
    ticks(2);
    reset = 1'b0;
    tick();

    // 123 / rem 5
    capture(9'h07B, 9'h005);
    check_latency("v1");
    check_out("v1", 1'b0, 12'h123, 12'h005);
    tick();
    check("v1_idle_ready", 32'(in_ready), 32'd1);
    check("v1_idle_valid", 32'(out_valid), 32'd0);
    check("v1_persist", 32'(res_bcd), 32'h123);

    // -255 / rem 0, with checks on when each output updates
    capture(9'h1FF, 9'h000);
    ticks(7);
    check("v2_res_hold", 32'(res_bcd), 32'h123);
    tick();
    check_out("v2_mid", 1'b1, 12'h255, 12'h005);
    ticks(7);
    check("v2_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("v2_valid", 32'(out_valid), 32'd1);
    check_out("v2", 1'b1, 12'h255, 12'h000);
    tick();

    // negative zero / rem 200
    capture(9'h100, 9'h0C8);
    check_latency("v3");
    check_out("v3", 1'b0, 12'h000, 12'h200);
    tick();

    // hold in DONE with out_ready low while in_valid and res_in keep changing
    out_ready = 1'b0;
    capture(9'h02A, 9'h007);
    check_latency("v4");
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_in = 9'(9'h0F0 + i);
      tick();
      check("v4_hold_valid", 32'(out_valid), 32'd1);
      check("v4_hold_ready", 32'(in_ready), 32'd0);
    end
    check_out("v4_hold", 1'b0, 12'h042, 12'h007);
    res_in    = 9'h063;
    rem_in    = 9'h001;
    out_ready = 1'b1;
    tick();
    check("v4_hs_ready", 32'(in_ready), 32'd1);
    check("v4_hs_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("v4_recapture", 32'(in_ready), 32'd0);
    check_latency("v4b");
    check_out("v4b", 1'b0, 12'h099, 12'h001);
    tick();

    // reset during the 7th conversion cycle aborts the transaction
    capture(9'h0C8, 9'h063);
    ticks(6);
    reset = 1'b1;
    #1;
    check("v5_rst_valid", 32'(out_valid), 32'd0);
    check("v5_rst_ready", 32'(in_ready), 32'd1);
    check_out("v5_rst", 1'b0, 12'h000, 12'h000);
    in_valid = 1'b1;
    tick();
    check("v5_no_cap_in_rst", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    reset    = 1'b0;
    capture(9'h00A, 9'h003);
    check_latency("v5");
    check_out("v5", 1'b0, 12'h010, 12'h003);
    tick();

    // back-to-back: one transaction every 2N+2 = 18 cycles
    in_valid = 1'b1;
    res_in   = b2b_res[0];
    rem_in   = b2b_rem[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        res_in = b2b_res[i+1];
        rem_in = b2b_rem[i+1];
      end else begin
        in_valid = 1'b0;
        res_in   = 9'h1AA;
        rem_in   = 9'h155;
      end
      check_latency("b2b");
      check_out("b2b", b2b_sign[i], b2b_rbcd[i], b2b_mbcd[i]);
      tick();
      check("b2b_ready", 32'(in_ready), 32'd1);
    end
    tick();
    check("b2b_end_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 Parameter: N, 8, magnitude width of quotient and remainder.
REQ-002 Parameter: D, 3, BCD digits per value (hundreds, tens, ones).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  divider result available.
REQ-006 in_ready  output  1  block accepts a new result.
REQ-007 res_in  input  N+1  quotient, sign-magnitude; bit N = sign, bits N-1:0 = magnitude.
REQ-008 rem_in  input  N+1  remainder; only bits N-1:0 used (magnitude), bit N ignored.
REQ-009 out_valid  output  1  formatted result held on outputs.
REQ-010 out_ready  input  1  downstream display consumes result.
REQ-011 res_sign  output  1  quotient sign for display minus segment.
REQ-012 res_bcd  output  4*D  quotient magnitude as BCD, [11:8] hundreds, [3:0] ones.
REQ-013 rem_bcd  output  4*D  remainder magnitude as BCD, same digit order.

Function
REQ-014 FSM states SHALL be IDLE, CONV_RES, CONV_REM, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid=1 at a rising edge, capture res_in and rem_in, clear iteration counter and BCD accumulator, go to CONV_RES.
REQ-017 CONV_RES: one shift-add-3 (double-dabble) iteration per cycle on the quotient magnitude, MSB first; after N iterations load result into res_bcd, go to CONV_REM.
REQ-018 CONV_REM: same algorithm on remainder magnitude, N iterations, load rem_bcd, go to DONE.
REQ-019 Latency SHALL be exactly 2*N cycles: capture at edge k, out_valid high after edge k+2N (16 for N=8).
REQ-020 Add-3 correction SHALL apply to every digit >= 5 before each shift; digits SHALL never exceed 9 at output.
REQ-021 res_sign SHALL equal captured sign bit, except forced 0 when captured magnitude is 0 (no negative zero).
REQ-022 DONE: res_sign, res_bcd, rem_bcd SHALL hold stable until out_valid and out_ready both 1 at an edge, then go to IDLE.
REQ-023 No bypass: in_ready SHALL not assert in the same cycle out_valid handshakes; earliest next capture is the following edge.
REQ-024 in_valid SHALL be ignored outside IDLE; res_in/rem_in changes after capture SHALL not affect the transaction.
REQ-025 Outputs res_sign/res_bcd/rem_bcd SHALL update only at the CONV_RES->CONV_REM and CONV_REM->DONE transitions; previous values persist otherwise.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, counter 0, accumulator 0, res_sign 0, res_bcd 0, rem_bcd 0, out_valid 0, in_ready 1.
REQ-027 reset asserted mid-conversion or in DONE SHALL abort the transaction with no output; first capture possible on first edge after release.

Structure
REQ-028 Package div_fmt_pkg SHALL hold state enum, N, D and BCD-digit width constant 4.
REQ-029 One combinational sub-module bcd_dabble_step SHALL perform one add-3-and-shift iteration (inputs: BCD accumulator, incoming bit; output: next accumulator), instantiated once and shared by both phases.

Verification
REQ-030 res_in=9'h07B, rem_in=9'h005, out_ready=1 -> res_sign=0, res_bcd=12'h123, rem_bcd=12'h005, out_valid exactly 16 cycles after capture.
REQ-031 res_in=9'h1FF, rem_in=9'h000 -> res_sign=1, res_bcd=12'h255, rem_bcd=12'h000.
REQ-032 res_in=9'h100 (negative zero), rem_in=9'h0C8 -> res_sign=0, res_bcd=12'h000, rem_bcd=12'h200.
REQ-033 out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing res_in -> outputs stable, in_ready=0, no second capture; capture occurs the edge after IDLE is re-entered.
REQ-034 reset pulsed at 7th conversion cycle -> out_valid=0, all outputs 0 immediately, in_ready=1; new transaction 9'h00A/9'h003 then yields 12'h010/12'h003.
REQ-035 Back-to-back: in_valid and out_ready tied 1 -> one transaction per 2N+2 cycles, each result correct for its captured inputs.
